vga_timing: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_gen.sv | 52 +++++
 rtl/vga_timing.sv | 86 ++++++++
 tb/tb_vga_timing.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Video mode constants and helpers shared by the raster timing generator.
package vga_timing_pkg;

    localparam int unsigned CNT_W_DEF = 11;

    // 800x600@60, 40 MHz pixel clock
    localparam int unsigned H_ACTIVE_800 = 800;
    localparam int unsigned H_FP_800     = 40;
    localparam int unsigned H_SYNC_800   = 128;
    localparam int unsigned H_BP_800     = 88;
    localparam int unsigned V_ACTIVE_600 = 600;
    localparam int unsigned V_FP_600     = 1;
    localparam int unsigned V_SYNC_600   = 4;
    localparam int unsigned V_BP_600     = 23;

    // 640x480@60, 25.175 MHz pixel clock
    localparam int unsigned H_ACTIVE_640 = 640;
    localparam int unsigned H_FP_640     = 16;
    localparam int unsigned H_SYNC_640   = 96;
    localparam int unsigned H_BP_640     = 48;
    localparam int unsigned V_ACTIVE_480 = 480;
    localparam int unsigned V_FP_480     = 10;
    localparam int unsigned V_SYNC_480   = 2;
    localparam int unsigned V_BP_480     = 33;

    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL_800 = axis_total(H_ACTIVE_800, H_FP_800, H_SYNC_800, H_BP_800);
    localparam int unsigned V_TOTAL_600 = axis_total(V_ACTIVE_600, V_FP_600, V_SYNC_600, V_BP_600);
    localparam int unsigned H_TOTAL_640 = axis_total(H_ACTIVE_640, H_FP_640, H_SYNC_640, H_BP_640);
    localparam int unsigned V_TOTAL_480 = axis_total(V_ACTIVE_480, V_FP_480, V_SYNC_480, V_BP_480);

endpackage

// File: rtl/vga_axis_gen.sv
// One raster axis: wrapping counter with registered sync window and blank flag.
// Outputs are computed from the next count so they always describe the same position.
module vga_axis_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned ACTIVE = H_ACTIVE_800,
    parameter int unsigned FP     = H_FP_800,
    parameter int unsigned SYNC   = H_SYNC_800,
    parameter int unsigned BP     = H_BP_800,
    parameter logic        POL    = 1'b1
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             blank,
    output logic             wrap_c
);

    localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int unsigned SYNC_FIRST = ACTIVE + FP;
    localparam int unsigned SYNC_LAST  = ACTIVE + FP + SYNC - 1;

    logic [CNT_W-1:0] count_nxt;
    logic             sync_nxt;
    logic             blank_nxt;

    always_comb begin
        wrap_c    = step && (count == CNT_W'(TOTAL - 1));
        count_nxt = count;
        if (step) begin
            count_nxt = wrap_c ? '0 : count + CNT_W'(1);
        end
        sync_nxt  = ((count_nxt >= CNT_W'(SYNC_FIRST)) && (count_nxt <= CNT_W'(SYNC_LAST))) ? POL : ~POL;
        blank_nxt = (count_nxt >= CNT_W'(ACTIVE));
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            count <= '0;
            sync  <= ~POL;
            blank <= 1'b0;
        end else begin
            count <= count_nxt;
            sync  <= sync_nxt;
            blank <= blank_nxt;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters, sync, blanking and frame-start pulse.
// Optional macro VGA_TIMING_CE_EN adds a clock-enable input so pclk may run at 2x/4x.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned H_ACTIVE = H_ACTIVE_800,
    parameter int unsigned H_FP     = H_FP_800,
    parameter int unsigned H_SYNC   = H_SYNC_800,
    parameter int unsigned H_BP     = H_BP_800,
    parameter int unsigned V_ACTIVE = V_ACTIVE_600,
    parameter int unsigned V_FP     = V_FP_600,
    parameter int unsigned V_SYNC   = V_SYNC_600,
    parameter int unsigned V_BP     = V_BP_600,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1
) (
    input  logic             pclk,
    input  logic             rst,
`ifdef VGA_TIMING_CE_EN
    input  logic             ce,
`endif
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             frame_start
);

    logic adv;
    logic h_wrap_c;
    logic v_wrap_c;

`ifdef VGA_TIMING_CE_EN
    assign adv = ce;
`else
    assign adv = 1'b1;
`endif

    vga_axis_gen #(
        .CNT_W (CNT_W),
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP),
        .POL   (HS_POL)
    ) u_h_axis (
        .pclk  (pclk),
        .rst   (rst),
        .step  (adv),
        .count (hcount),
        .sync  (hsync),
        .blank (hblnk),
        .wrap_c(h_wrap_c)
    );

    // Vertical axis steps once per line, so vsync/vblnk only move with the hcount wrap
    vga_axis_gen #(
        .CNT_W (CNT_W),
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP),
        .POL   (VS_POL)
    ) u_v_axis (
        .pclk  (pclk),
        .rst   (rst),
        .step  (h_wrap_c),
        .count (vcount),
        .sync  (vsync),
        .blank (vblnk),
        .wrap_c(v_wrap_c)
    );

    // v_wrap_c already implies the horizontal wrap, i.e. the next cell is (0,0)
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else if (adv) begin
            frame_start <= v_wrap_c;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing using a reduced mode (25x11 raster) with mixed sync polarities.
module tb_vga_timing;

    localparam int unsigned CNT_W  = 5;
    localparam int          HA     = 16;
    localparam int          HF     = 2;
    localparam int          HS     = 4;
    localparam int          HB     = 3;
    localparam int          VA     = 6;
    localparam int          VF     = 1;
    localparam int          VS     = 2;
    localparam int          VB     = 2;
    localparam logic        HS_POL = 1'b1;
    localparam logic        VS_POL = 1'b0;
    localparam int          HT     = HA + HF + HS + HB;
    localparam int          VT     = VA + VF + VS + VB;
`ifdef VGA_TIMING_CE_EN
    localparam int          CE_DIV = 4;
`else
    localparam int          CE_DIV = 1;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] v;
        logic             hs;
        logic             vs;
        logic             hb;
        logic             vb;
        logic             fs;
    } obs_t;

    logic             pclk;
    logic             rst;
    logic             ce;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    logic             frame_start;

    int   n_checks;
    int   n_errors;
    obs_t exp_q[$];
    int   mh;
    int   mv;
    logic mfs;
    int   cyc;
    int   adv_cnt;
    int   fs_at;
    int   n_hs;
    int   n_vs;
    int   n_hb;
    int   n_vb;
    int   n_fs;

    vga_timing #(
        .CNT_W   (CNT_W),
        .H_ACTIVE(HA),
        .H_FP    (HF),
        .H_SYNC  (HS),
        .H_BP    (HB),
        .V_ACTIVE(VA),
        .V_FP    (VF),
        .V_SYNC  (VS),
        .V_BP    (VB),
        .HS_POL  (HS_POL),
        .VS_POL  (VS_POL)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
`ifdef VGA_TIMING_CE_EN
        .ce         (ce),
`endif
        .hcount     (hcount),
        .vcount     (vcount),
        .hsync      (hsync),
        .vsync      (vsync),
        .hblnk      (hblnk),
        .vblnk      (vblnk),
        .frame_start(frame_start)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t reset_obs();
        obs_t o;
        o.h  = '0;
        o.v  = '0;
        o.hs = ~HS_POL;
        o.vs = ~VS_POL;
        o.hb = 1'b0;
        o.vb = 1'b0;
        o.fs = 1'b0;
        return o;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.h  = CNT_W'(mh);
        o.v  = CNT_W'(mv);
        o.hs = (mh >= HA + HF && mh <= HA + HF + HS - 1) ? HS_POL : ~HS_POL;
        o.vs = (mv >= VA + VF && mv <= VA + VF + VS - 1) ? VS_POL : ~VS_POL;
        o.hb = (mh >= HA);
        o.vb = (mv >= VA);
        o.fs = mfs;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.h  = hcount;
        o.v  = vcount;
        o.hs = hsync;
        o.vs = vsync;
        o.hb = hblnk;
        o.vb = vblnk;
        o.fs = frame_start;
        return o;
    endfunction

    // One pclk edge: predict, push, clock, pop and compare
    task automatic run_cycle();
        obs_t e;
        obs_t g;
        logic was_adv;
        ce = (CE_DIV == 1) ? 1'b1 : ((cyc % CE_DIV) == 0);
        was_adv = 1'b0;
        if (rst) begin
            mh  = 0;
            mv  = 0;
            mfs = 1'b0;
            exp_q.push_back(reset_obs());
        end else begin
            if (ce) begin
                was_adv = 1'b1;
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
                mfs = (mh == 0 && mv == 0);
                adv_cnt++;
            end
            exp_q.push_back(model_out());
        end
        @(posedge pclk);
        #1;
        cyc++;
        g = dut_obs();
        e = exp_q.pop_front();
        check($sformatf("px(%0d,%0d)", e.h, e.v), 32'(g), 32'(e));
        if (was_adv && adv_cnt <= HT * VT) begin
            if (hsync == HS_POL) n_hs++;
            if (vsync == VS_POL) n_vs++;
            if (hblnk) n_hb++;
            if (vblnk) n_vb++;
            if (frame_start) n_fs++;
        end
        if (frame_start && fs_at < 0) fs_at = adv_cnt;
    endtask

    // Run a frame plus one line from (0,0) and check aggregate timing
    task automatic run_frame(input string tag);
        adv_cnt = 0;
        fs_at   = -1;
        n_hs    = 0;
        n_vs    = 0;
        n_hb    = 0;
        n_vb    = 0;
        n_fs    = 0;
        for (int i = 0; i < CE_DIV * (HT * VT + HT); i++) run_cycle();
        check({tag, "_fs_latency"}, 32'(fs_at), 32'(HT * VT));
        check({tag, "_fs_count"},   32'(n_fs),  32'(1));
        check({tag, "_hsync_cells"}, 32'(n_hs), 32'(HS * VT));
        check({tag, "_vsync_cells"}, 32'(n_vs), 32'(VS * HT));
        check({tag, "_hblnk_cells"}, 32'(n_hb), 32'((HT - HA) * VT));
        check({tag, "_vblnk_cells"}, 32'(n_vb), 32'((VT - VA) * HT));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        mh       = 0;
        mv       = 0;
        mfs      = 1'b0;
        ce       = 1'b1;
        rst      = 1'b1;
        for (int i = 0; i < 5; i++) run_cycle();
        rst = 1'b0;
        run_frame("f1");

        // Walk to a cell inside both sync windows and blanking, then reset between edges
        for (int i = 0; i < CE_DIV * HT * VT && !(mh == HA + HF + 1 && mv == VA + VF); i++) run_cycle();
        check("reach_mid_h", 32'(hcount), 32'(HA + HF + 1));
        check("reach_mid_v", 32'(vcount), 32'(VA + VF));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'(dut_obs()), 32'(reset_obs()));
        for (int i = 0; i < 2; i++) run_cycle();
        rst = 1'b0;
        run_frame("f2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
